// File: rtl/reduce_pkg.sv
// Shared types and elaboration helpers for the pipelined reduction tree.
//   red_op_e      : reduction operator carried with each transaction
//   identity_bit  : padding bit that leaves a reduction unchanged
//   ipow / treeLevels / levelOffset : tree geometry for generate loops
package reduce_pkg;

  typedef enum logic [1:0] {
    RED_OR  = 2'd0,
    RED_AND = 2'd1,
    RED_XOR = 2'd2,
    RED_NOR = 2'd3
  } red_op_e;

  // AND needs 1s as neutral filler; OR/XOR/NOR need 0s.
  function automatic logic identity_bit(input red_op_e op);
    return (op == RED_AND);
  endfunction

  function automatic int unsigned ipow(input int unsigned base, input int unsigned expn);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < expn; i++) r = r * base;
    return r;
  endfunction

  // ceil(log_radix(width)); guarded against a degenerate radix.
  function automatic int unsigned treeLevels(input int unsigned width, input int unsigned radix);
    int unsigned span;
    int unsigned lv;
    span = 1;
    lv   = 0;
    if (radix < 2) return 1;
    while (span < width) begin
      span = span * radix;
      lv++;
    end
    return lv;
  endfunction

  // Flat index of the first node of tree level lvl (levels counted from 1).
  function automatic int unsigned levelOffset(input int unsigned levels, input int unsigned radix,
                                              input int unsigned lvl);
    int unsigned off;
    off = 0;
    for (int unsigned m = 1; m < lvl; m++) off = off + ipow(radix, levels - m);
    return off;
  endfunction

endpackage

// File: rtl/reduce_node.sv
// Combinational RADIX-input tree node.
//   op       : reduction operator (NOR reduces as OR here)
//   bits     : child partial reductions
//   anys     : child "some real bit set" flags
//   idxs     : child lowest-set-bit indices, packed, child 0 in the LSBs
//   result_c : reduction of bits
//   any_c    : OR of anys
//   idx_c    : index of lowest set bit below this node, 0 if none
module reduce_node
  import reduce_pkg::*;
#(
  parameter int unsigned RADIX = 4,
  parameter int unsigned IDX_W = 6,
  parameter int unsigned SPAN  = 1
) (
  input  red_op_e                op,
  input  logic [RADIX-1:0]       bits,
  input  logic [RADIX-1:0]       anys,
  input  logic [RADIX*IDX_W-1:0] idxs,
  output logic                   result_c,
  output logic                   any_c,
  output logic [IDX_W-1:0]       idx_c
);

  // SPAN is the leaf count under each child, so k*SPAN is the child's base index.
  always_comb begin
    result_c = 1'b0;
    any_c    = |anys;
    idx_c    = '0;
    case (op)
      RED_AND: result_c = &bits;
      RED_XOR: result_c = ^bits;
      default: result_c = |bits;
    endcase
    // Scan high to low so the lowest child with a set bit wins.
    for (int k = RADIX - 1; k >= 0; k--) begin
      if (anys[k]) idx_c = IDX_W'(k * SPAN) + idxs[k*IDX_W +: IDX_W];
    end
  end

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined WIDTH-input bitwise reduction (OR/AND/XOR/NOR) with lowest-set-bit
// index and a pass-through tag. One tree level per register stage, so a
// result appears LEVELS cycles after acceptance; throughput one per clock.
//   clk, reset_n          : clock, async active-low reset
//   flush                 : kill everything in flight, refuse input this cycle
//   in_valid / in_ready   : input handshake (in_ready is combinational)
//   in_data, in_op, in_tag: vector, operator, requester tag
//   out_valid / out_ready : output handshake; outputs hold while stalled
//   out_result, out_any, out_idx, out_tag : registered result fields
module reduce_tree_pipe
  import reduce_pkg::*;
#(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned RADIX = 4,
  parameter  int unsigned TAG_W = 6,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  red_op_e          in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic             out_any,
  output logic [IDX_W-1:0] out_idx,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned LEVELS = treeLevels(WIDTH, RADIX);
  localparam int unsigned PADW   = ipow(RADIX, LEVELS);
  localparam int unsigned NREG   = levelOffset(LEVELS, RADIX, LEVELS + 1);
  localparam int unsigned OPN    = (LEVELS > 1) ? LEVELS - 1 : 1;

  if (WIDTH < 2) begin : gBadWidth
    $error("reduce_tree_pipe: WIDTH must be at least 2");
  end
  if (RADIX < 2 || RADIX > 8) begin : gBadRadix
    $error("reduce_tree_pipe: RADIX must be in 2..8");
  end

  // Leaves, padded to a full tree with bits that cannot affect the result.
  logic [PADW-1:0] leafBit;
  logic [PADW-1:0] leafAny;

  // All registered tree levels flattened; the last node is the output stage.
  logic [NREG-1:0]  nodeBit, regBit;
  logic [NREG-1:0]  nodeAny, regAny;
  logic [IDX_W-1:0] nodeIdx [NREG];
  logic [IDX_W-1:0] regIdx  [NREG];

  logic [LEVELS-1:0] stValid;
  logic [TAG_W-1:0]  stTag [LEVELS];
  red_op_e           stOp  [OPN];
  red_op_e           levelOp [LEVELS];

  logic stall;
  logic accept;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall && !flush;
  assign accept   = in_valid && in_ready;

  for (genvar j = 0; j < PADW; j++) begin : gLeaf
    if (j < WIDTH) begin : gData
      assign leafBit[j] = in_data[j];
      assign leafAny[j] = in_data[j];
    end else begin : gPad
      assign leafBit[j] = identity_bit(in_op);
      assign leafAny[j] = 1'b0;
    end
  end

  // Operator feeding each tree level travels with its stage.
  always_comb begin
    levelOp[0] = in_op;
    for (int l = 1; l < LEVELS; l++) levelOp[l] = stOp[l-1];
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : gLvl
    localparam int unsigned NN   = ipow(RADIX, LEVELS - l);
    localparam int unsigned OFF  = levelOffset(LEVELS, RADIX, l);
    localparam int unsigned POFF = levelOffset(LEVELS, RADIX, l - 1);
    for (genvar n = 0; n < NN; n++) begin : gNode
      logic [RADIX-1:0]       cBit;
      logic [RADIX-1:0]       cAny;
      logic [RADIX*IDX_W-1:0] cIdx;
      for (genvar k = 0; k < RADIX; k++) begin : gChild
        if (l == 1) begin : gFromLeaf
          assign cBit[k]                 = leafBit[n*RADIX + k];
          assign cAny[k]                 = leafAny[n*RADIX + k];
          assign cIdx[k*IDX_W +: IDX_W]  = '0;
        end else begin : gFromReg
          assign cBit[k]                 = regBit[POFF + n*RADIX + k];
          assign cAny[k]                 = regAny[POFF + n*RADIX + k];
          assign cIdx[k*IDX_W +: IDX_W]  = regIdx[POFF + n*RADIX + k];
        end
      end
      reduce_node #(
        .RADIX(RADIX),
        .IDX_W(IDX_W),
        .SPAN (ipow(RADIX, l - 1))
      ) uNode (
        .op      (levelOp[l-1]),
        .bits    (cBit),
        .anys    (cAny),
        .idxs    (cIdx),
        .result_c(nodeBit[OFF + n]),
        .any_c   (nodeAny[OFF + n]),
        .idx_c   (nodeIdx[OFF + n])
      );
    end
  end

  // Stage registers: global stall freezes everything, flush kills valids only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stValid <= '0;
      for (int l = 0; l < LEVELS; l++) stTag[l] <= '0;
      for (int l = 0; l < OPN; l++) stOp[l] <= RED_OR;
      regBit <= '0;
      regAny <= '0;
      for (int i = 0; i < NREG; i++) regIdx[i] <= '0;
    end else if (flush) begin
      stValid <= '0;
    end else if (!stall) begin
      stValid[0] <= accept;
      stTag[0]   <= in_tag;
      stOp[0]    <= in_op;
      for (int l = 1; l < LEVELS; l++) begin
        stValid[l] <= stValid[l-1];
        stTag[l]   <= stTag[l-1];
      end
      for (int l = 1; l < OPN; l++) stOp[l] <= stOp[l-1];
      regBit <= nodeBit;
      // NOR is OR through the tree and only inverted entering the output stage.
      regBit[NREG-1] <= nodeBit[NREG-1] ^ (levelOp[LEVELS-1] == RED_NOR);
      regAny <= nodeAny;
      for (int i = 0; i < NREG; i++) regIdx[i] <= nodeIdx[i];
    end
  end

  assign out_valid  = stValid[LEVELS-1];
  assign out_tag    = stTag[LEVELS-1];
  assign out_result = regBit[NREG-1];
  assign out_any    = regAny[NREG-1];
  assign out_idx    = regIdx[NREG-1];

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Randomized and directed bench for reduce_tree_pipe. A 64-bit and a 48-bit
// instance share all controls; the 48-bit one sees in_data[47:0].
module tb_reduce_tree_pipe;
  import reduce_pkg::*;

  localparam int LV = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  red_op_e    in_op = RED_OR;
  logic [63:0] in_data = '0;
  logic [5:0]  in_tag = '0;

  logic       in_ready, out_valid, out_result, out_any;
  logic [5:0] out_idx, out_tag;
  logic       in_ready48, out_valid48, out_result48, out_any48;
  logic [5:0] out_idx48, out_tag48;

  always #5 clk = ~clk;

  reduce_tree_pipe #(.WIDTH(64), .RADIX(4), .TAG_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_any(out_any), .out_idx(out_idx), .out_tag(out_tag)
  );

  reduce_tree_pipe #(.WIDTH(48), .RADIX(4), .TAG_W(6)) dut48 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready48), .in_data(in_data[47:0]),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid48), .out_ready(out_ready), .out_result(out_result48),
    .out_any(out_any48), .out_idx(out_idx48), .out_tag(out_tag48)
  );

  typedef struct {
    bit v;
    bit r64; bit a64; int i64;
    bit r48; bit a48; int i48;
    int tag;
  } exp_t;

  exp_t pipe [LV];
  int   nVec = 0;
  int   nErr = 0;
  bit   chkEn = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nVec++;
    if (act !== expv) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  // Reference reduction over the low w bits, straight from the definition.
  function automatic void calc(input red_op_e op, input logic [63:0] d, input int w,
                               output bit r, output bit a, output int i);
    int ones;
    ones = 0; a = 1'b0; i = 0; r = 1'b0;
    for (int b = w - 1; b >= 0; b--) begin
      if (d[b] === 1'b1) begin ones++; a = 1'b1; i = b; end
    end
    case (op)
      RED_OR:  r = a;
      RED_AND: r = (ones == w);
      RED_XOR: r = (ones % 2) == 1;
      default: r = !a;
    endcase
  endfunction

  function automatic exp_t mkExp(input red_op_e op, input logic [63:0] d, input logic [5:0] t);
    exp_t e;
    e.v = 1'b1;
    e.tag = int'(t);
    calc(op, d, 64, e.r64, e.a64, e.i64);
    calc(op, d, 48, e.r48, e.a48, e.i48);
    return e;
  endfunction

  function automatic exp_t emptyExp();
    exp_t e;
    e = '{default: 0};
    return e;
  endfunction

  // Apply one cycle of inputs and advance the reference pipeline at the edge.
  task automatic step(input bit v, input red_op_e op, input logic [63:0] d,
                      input logic [5:0] t, input bit ordy, input bit fl);
    bit stall, acc;
    @(negedge clk); #1;
    in_valid = v; in_op = op; in_data = d; in_tag = t; out_ready = ordy; flush = fl;
    @(posedge clk);
    stall = pipe[LV-1].v && !out_ready;
    acc   = in_valid && !stall && !flush;
    if (!reset_n) begin
      for (int i = 0; i < LV; i++) pipe[i] = emptyExp();
    end else if (flush) begin
      for (int i = 0; i < LV; i++) pipe[i].v = 1'b0;
    end else if (!stall) begin
      for (int i = LV - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = acc ? mkExp(in_op, in_data, in_tag) : emptyExp();
    end
  endtask

  task automatic idle();
    step(1'b0, RED_OR, 64'd0, 6'd0, 1'b1, 1'b0);
  endtask

  task automatic chkZero(input string name);
    chk({name, "_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_result"}, 64'(out_result), 64'd0);
    chk({name, "_any"}, 64'(out_any), 64'd0);
    chk({name, "_idx"}, 64'(out_idx), 64'd0);
    chk({name, "_tag"}, 64'(out_tag), 64'd0);
    chk({name, "_valid48"}, 64'(out_valid48), 64'd0);
    chk({name, "_tag48"}, 64'(out_tag48), 64'd0);
  endtask

  // Cycle-by-cycle comparison against the reference pipeline.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (chkEn) begin
      e = pipe[LV-1];
      chk("out_valid", 64'(out_valid), 64'(e.v));
      chk("out_valid48", 64'(out_valid48), 64'(e.v));
      chk("in_ready", 64'(in_ready), 64'(!(e.v && !out_ready) && !flush));
      chk("in_ready48", 64'(in_ready48), 64'(!(e.v && !out_ready) && !flush));
      if (e.v) begin
        chk("out_result", 64'(out_result), 64'(e.r64));
        chk("out_any", 64'(out_any), 64'(e.a64));
        chk("out_idx", 64'(out_idx), 64'(e.i64));
        chk("out_tag", 64'(out_tag), 64'(e.tag));
        chk("out_result48", 64'(out_result48), 64'(e.r48));
        chk("out_any48", 64'(out_any48), 64'(e.a48));
        chk("out_idx48", 64'(out_idx48), 64'(e.i48));
        chk("out_tag48", 64'(out_tag48), 64'(e.tag));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [63:0] d;
    for (int i = 0; i < LV; i++) pipe[i] = emptyExp();

    // Reset state
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chkZero("reset");
    @(negedge clk); #3 reset_n = 1'b1;
    chkEn = 1'b1;

    // OR single bit: 3-cycle latency, idx 40
    step(1'b1, RED_OR, 64'h0000_0100_0000_0000, 6'd5, 1'b1, 1'b0);
    idle(); #1;
    chk("t1_early_valid", 64'(out_valid), 64'd0);
    idle(); #1;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_result", 64'(out_result), 64'd1);
    chk("t1_any", 64'(out_any), 64'd1);
    chk("t1_idx", 64'(out_idx), 64'd40);
    chk("t1_tag", 64'(out_tag), 64'd5);

    // AND back-to-back
    step(1'b1, RED_AND, 64'hFFFF_FFFF_FFFF_FFFF, 6'd1, 1'b1, 1'b0);
    step(1'b1, RED_AND, 64'hFFFF_FFFF_FFFF_FFFE, 6'd2, 1'b1, 1'b0);
    idle(); #1;
    chk("t2a_result", 64'(out_result), 64'd1);
    chk("t2a_idx", 64'(out_idx), 64'd0);
    idle(); #1;
    chk("t2b_valid", 64'(out_valid), 64'd1);
    chk("t2b_result", 64'(out_result), 64'd0);
    chk("t2b_idx", 64'(out_idx), 64'd1);

    // XOR, then padding identity on the 48-bit build
    step(1'b1, RED_XOR, 64'h8000_0000_0000_0001, 6'd3, 1'b1, 1'b0);
    step(1'b1, RED_AND, 64'hFFFF_FFFF_FFFF_FFFF, 6'd4, 1'b1, 1'b0);
    step(1'b1, RED_OR, 64'd0, 6'd6, 1'b1, 1'b0);
    #1;
    chk("t3_xor_result", 64'(out_result), 64'd0);
    chk("t3_xor_idx", 64'(out_idx), 64'd0);
    chk("t3_xor_result48", 64'(out_result48), 64'd1);
    idle(); #1;
    chk("t3_and_result48", 64'(out_result48), 64'd1);
    idle(); #1;
    chk("t3_or0_result48", 64'(out_result48), 64'd0);
    chk("t3_or0_any48", 64'(out_any48), 64'd0);
    chk("t3_or0_idx48", 64'(out_idx48), 64'd0);

    // Backpressure: 3 queued, hold 5 cycles, release
    step(1'b1, RED_OR, 64'h10, 6'd7, 1'b1, 1'b0);
    step(1'b1, RED_OR, 64'h20, 6'd8, 1'b1, 1'b0);
    step(1'b1, RED_OR, 64'h40, 6'd9, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, RED_XOR, 64'hFF, 6'd33, 1'b0, 1'b0); #1;
      chk("t4_in_ready", 64'(in_ready), 64'd0);
      chk("t4_hold_tag", 64'(out_tag), 64'd7);
      chk("t4_hold_idx", 64'(out_idx), 64'd4);
    end
    idle(); #1;
    chk("t4_second_tag", 64'(out_tag), 64'd8);
    idle(); #1;
    chk("t4_third_tag", 64'(out_tag), 64'd9);
    idle(); #1;
    chk("t4_drained", 64'(out_valid), 64'd0);

    // Flush with work in flight
    step(1'b1, RED_OR, 64'h1, 6'd10, 1'b1, 1'b0);
    step(1'b1, RED_OR, 64'h2, 6'd11, 1'b1, 1'b0);
    step(1'b1, RED_OR, 64'h4, 6'd12, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      idle(); #1;
      chk("t5_flushed", 64'(out_valid), 64'd0);
    end
    step(1'b1, RED_NOR, 64'd0, 6'd13, 1'b1, 1'b0);
    idle(); #1;
    chk("t5_early", 64'(out_valid), 64'd0);
    idle(); #1;
    chk("t5_valid", 64'(out_valid), 64'd1);
    chk("t5_tag", 64'(out_tag), 64'd13);
    chk("t5_nor", 64'(out_result), 64'd1);

    // Async reset mid-stream
    step(1'b1, RED_OR, 64'h20, 6'd9, 1'b1, 1'b0);
    idle();
    idle();
    #3 reset_n = 1'b0;
    for (int i = 0; i < LV; i++) pipe[i] = emptyExp();
    #1;
    chkZero("t6_async");
    idle();
    #3 reset_n = 1'b1;
    step(1'b1, RED_AND, 64'hFFFF_FFFF_FFFF_FFFF, 6'd14, 1'b1, 1'b0);
    idle(); #1;
    chk("t6_early", 64'(out_valid), 64'd0);
    idle(); #1;
    chk("t6_valid", 64'(out_valid), 64'd1);
    chk("t6_tag", 64'(out_tag), 64'd14);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 5))
        0: d = 64'd0;
        1: d = 64'hFFFF_FFFF_FFFF_FFFF;
        2: d = 64'd1 << $urandom_range(0, 63);
        3: d = ~(64'd1 << $urandom_range(0, 63));
        4: d = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        default: d = {$urandom, $urandom};
      endcase
      step(($urandom_range(0, 9) < 7), red_op_e'(2'($urandom_range(0, 3))), d,
           6'($urandom_range(0, 63)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 31) == 0));
    end
    repeat (6) idle();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
